// File: rtl/nmi_core_arb.sv
// NUM_CORE-to-one NMI master arbiter with delayed core reset release and bus timeout.
// Optional `NMI_ARB_ADDR_REMAP_EN folds 0x30/0xA0 top-byte core maps onto 0x00/0x40.
module nmi_core_arb #(
  parameter int unsigned NUM_CORE    = 2,
  parameter int unsigned RST_DLY_W   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF,
  localparam int unsigned GW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    rr_en_i,
  output logic [NUM_CORE-1:0]     core_rst_n_o,
  input  logic [NUM_CORE-1:0]     m_valid_i,
  input  logic [NUM_CORE*32-1:0]  m_addr_i,
  input  logic [NUM_CORE*32-1:0]  m_wdata_i,
  input  logic [NUM_CORE*4-1:0]   m_wstrb_i,
  output logic [31:0]             m_rdata_o,
  output logic [NUM_CORE-1:0]     m_ready_o,
  output logic                    s_valid_o,
  output logic [31:0]             s_addr_o,
  output logic [31:0]             s_wdata_o,
  output logic [3:0]              s_wstrb_o,
  input  logic [31:0]             s_rdata_i,
  input  logic                    s_ready_i,
  output logic [GW-1:0]           grant_o,
  output logic                    err_o,
  output logic [GW-1:0]           err_id_o
);

  localparam int          NC = int'(NUM_CORE);
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [RST_DLY_W-1:0] dly_cnt;
  logic [RST_DLY_W-1:0] dly_next;
  logic                 released;
  logic [GW-1:0]        ptr;
  logic [GW-1:0]        ptr_next;
  logic [TW-1:0]        to_cnt;
  logic                 to_hit;
  logic                 done_c;
  logic [31:0]          rdata_q;
  logic [NUM_CORE-1:0]  req;
  logic                 win_found;
  logic [GW-1:0]        win;
  logic [31:0]          sel_addr;

  assign dly_next     = (&dly_cnt) ? dly_cnt : dly_cnt + RST_DLY_W'(1);
  assign core_rst_n_o = {NUM_CORE{released}};
  assign req          = m_valid_i & {NUM_CORE{released}};
  assign to_hit       = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);
  assign done_c       = (state == BUSY) && (s_ready_i || to_hit);
  assign ptr_next     = (int'(grant_o) >= NC - 1) ? '0 : grant_o + GW'(1);
  assign m_ready_o    = done_c ? (NUM_CORE'(1) << grant_o) : '0;
  assign m_rdata_o    = done_c ? (s_ready_i ? s_rdata_i : ERR_RDATA) : rdata_q;

  // Winner search: upward from the RR pointer (wrapping), or from index 0 in fixed mode.
  always_comb begin
    int base;
    int j;
    win_found = 1'b0;
    win       = '0;
    base      = rr_en_i ? int'(ptr) : 0;
    j         = 0;
    for (int i = 0; i < NC; i++) begin
      j = base + i;
      if (j >= NC) j = j - NC;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win       = GW'(j);
      end
    end
  end

  // Downstream request fields follow the granted core.
  always_comb begin
    sel_addr  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    for (int c = 0; c < NC; c++) begin
      if (grant_o == GW'(c)) begin
        sel_addr  = m_addr_i[32*c +: 32];
        s_wdata_o = m_wdata_i[32*c +: 32];
        s_wstrb_o = m_wstrb_i[4*c +: 4];
      end
    end
  end

`ifdef NMI_ARB_ADDR_REMAP_EN
  always_comb begin
    s_addr_o = sel_addr;
    case (sel_addr[31:24])
      8'h30:   s_addr_o = {8'h00, sel_addr[23:0]};
      8'hA0:   s_addr_o = {8'h40, sel_addr[23:0]};
      default: s_addr_o = sel_addr;
    endcase
  end
`else
  assign s_addr_o = sel_addr;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      released  <= 1'b0;
      ptr       <= '0;
      to_cnt    <= '0;
      rdata_q   <= '0;
      s_valid_o <= 1'b0;
      grant_o   <= '0;
      err_o     <= 1'b0;
      err_id_o  <= '0;
    end else begin
      dly_cnt  <= dly_next;
      released <= &dly_next;
      rdata_q  <= m_rdata_o;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_o   <= win;
            to_cnt    <= '0;
            s_valid_o <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          to_cnt <= to_cnt + TW'(1);
          if (done_c) begin
            ptr       <= ptr_next;
            s_valid_o <= 1'b0;
            state     <= DONE;
            // A slave completion wins over a coincident timeout.
            if (!s_ready_i) begin
              err_o <= 1'b1;
              if (!err_o) err_id_o <= grant_o;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmi_core_arb.sv
// Randomized self-checking bench for nmi_core_arb against a transaction-level model.
module tb_nmi_core_arb;
  localparam int N  = 2;
  localparam int DW = 4;
  localparam int TO = 8;
  localparam int HOLD = (1 << DW) - 1;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            rst_n_i;
  logic            rr_en_i;
  logic [N-1:0]    core_rst_n_o;
  logic [N-1:0]    m_valid_i;
  logic [N*32-1:0] m_addr_i;
  logic [N*32-1:0] m_wdata_i;
  logic [N*4-1:0]  m_wstrb_i;
  logic [31:0]     m_rdata_o;
  logic [N-1:0]    m_ready_o;
  logic            s_valid_o;
  logic [31:0]     s_addr_o;
  logic [31:0]     s_wdata_o;
  logic [3:0]      s_wstrb_o;
  logic [31:0]     s_rdata_i;
  logic            s_ready_i;
  logic [0:0]      grant_o;
  logic            err_o;
  logic [0:0]      err_id_o;

  int vectors = 0;
  int errors  = 0;

  // Transaction-level model state
  int ptr_m;
  bit err_m;
  int err_id_m;
  logic [31:0] addr_q [N];
  logic [31:0] wdata_q[N];
  logic [3:0]  wstrb_q[N];

  nmi_core_arb #(.NUM_CORE(N), .RST_DLY_W(DW), .TIMEOUT_CYC(TO), .ERR_RDATA(ERRD)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .rr_en_i(rr_en_i), .core_rst_n_o(core_rst_n_o),
    .m_valid_i(m_valid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_rdata_o(m_rdata_o), .m_ready_o(m_ready_o), .s_valid_o(s_valid_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
    .grant_o(grant_o), .err_o(err_o), .err_id_o(err_id_o)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] req, input bit rr, input int p);
    for (int i = 0; i < N; i++) begin
      int c;
      c = rr ? (p + i) % N : i;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef NMI_ARB_ADDR_REMAP_EN
    if (a[31:24] == 8'h30) return {8'h00, a[23:0]};
    if (a[31:24] == 8'hA0) return {8'h40, a[23:0]};
`endif
    return a;
  endfunction

  task automatic drive_bus();
    for (int c = 0; c < N; c++) begin
      m_addr_i[32*c +: 32] = addr_q[c];
      m_wdata_i[32*c +: 32] = wdata_q[c];
      m_wstrb_i[4*c +: 4] = wstrb_q[c];
    end
  endtask

  task automatic model_reset();
    ptr_m = 0; err_m = 0; err_id_m = 0;
  endtask

  // Release reset and check the hold window; cores keep requesting throughout it.
  task automatic hold_release();
    @(negedge clk);
    rst_n_i = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge clk);
      m_valid_i = (k < HOLD) ? '1 : '0;
      #1;
      vectors++;
      if (core_rst_n_o !== ((k >= HOLD) ? '1 : '0)) begin
        errors++; $display("FAIL hold_core_rst k=%0d: got %b want %b", k, core_rst_n_o, (k >= HOLD) ? 2'b11 : 2'b00);
      end
      vectors++;
      if (s_valid_o !== 1'b0) begin
        errors++; $display("FAIL hold_s_valid k=%0d: got %b want 0", k, s_valid_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; rr_en_i = 1'b0; m_valid_i = '0; s_ready_i = 1'b0; s_rdata_i = '0;
    for (int c = 0; c < N; c++) begin
      addr_q[c] = $urandom; wdata_q[c] = $urandom; wstrb_q[c] = 4'(c);
    end
    drive_bus();
    model_reset();
    @(negedge clk); #1;
    vectors++;
    if ({core_rst_n_o, s_valid_o, m_ready_o, grant_o, err_o, err_id_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got rst=%b sv=%b rdy=%b g=%0d err=%b id=%0d want all zero",
                         core_rst_n_o, s_valid_o, m_ready_o, grant_o, err_o, err_id_o);
    end
    vectors++;
    if (m_rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", m_rdata_o);
    end
    hold_release();
  endtask

  // One arbitrated transaction from an IDLE cycle through its DONE cycle.
  task automatic txn(input logic [N-1:0] req, input int wt, input logic [31:0] rd, input bit rr);
    int w, last;
    bit to;
    logic [31:0] exp_rd;
    w = pick(req, rr, ptr_m);
    to = (wt >= TO);
    last = to ? TO - 1 : wt;
    exp_rd = to ? ERRD : rd;
    @(negedge clk);
    m_valid_i = req; rr_en_i = rr; s_ready_i = 1'($urandom_range(0, 1)); s_rdata_i = $urandom;
    drive_bus();
    #1;
    vectors++;
    if (s_valid_o !== 1'b0 || m_ready_o !== '0) begin
      errors++; $display("FAIL idle_quiet: got sv=%b rdy=%b want 0/00", s_valid_o, m_ready_o);
    end
    for (int b = 0; b <= last; b++) begin
      @(negedge clk);
      rr_en_i = 1'($urandom_range(0, 1));
      s_ready_i = (b == wt);
      s_rdata_i = (b == wt) ? rd : $urandom;
      #1;
      vectors++;
      if (s_valid_o !== 1'b1 || int'(grant_o) != w) begin
        errors++; $display("FAIL busy_grant b=%0d: got sv=%b g=%0d want 1/%0d", b, s_valid_o, grant_o, w);
      end
      vectors++;
      if (s_addr_o !== exp_addr(addr_q[w]) || s_wdata_o !== wdata_q[w] || s_wstrb_o !== wstrb_q[w]) begin
        errors++; $display("FAIL busy_fields b=%0d: got %h/%h/%h want %h/%h/%h", b, s_addr_o, s_wdata_o,
                           s_wstrb_o, exp_addr(addr_q[w]), wdata_q[w], wstrb_q[w]);
      end
      vectors++;
      if (b == last) begin
        if (m_ready_o !== (N'(1) << w) || m_rdata_o !== exp_rd) begin
          errors++; $display("FAIL complete: got rdy=%b rdata=%h want %b/%h", m_ready_o, m_rdata_o, N'(1) << w, exp_rd);
        end
      end else if (m_ready_o !== '0) begin
        errors++; $display("FAIL early_ready b=%0d: got %b want 00", b, m_ready_o);
      end
    end
    ptr_m = (w + 1) % N;
    if (to) begin
      if (!err_m) err_id_m = w;
      err_m = 1;
    end
    @(negedge clk);
    m_valid_i = req & ~(N'(1) << w);
    s_ready_i = 1'b1; s_rdata_i = $urandom;
    addr_q[w] = $urandom; wdata_q[w] = $urandom; wstrb_q[w] = 4'($urandom);
    drive_bus();
    #1;
    vectors++;
    if (s_valid_o !== 1'b0 || m_ready_o !== '0) begin
      errors++; $display("FAIL done_quiet: got sv=%b rdy=%b want 0/00", s_valid_o, m_ready_o);
    end
    vectors++;
    if (err_o !== err_m || int'(err_id_o) != err_id_m) begin
      errors++; $display("FAIL err_flag: got %b/%0d want %b/%0d", err_o, err_id_o, err_m, err_id_m);
    end
    s_ready_i = 1'b0;
  endtask

  task automatic test_zero_wait();
    addr_q[0] = 32'h1000_0040; wstrb_q[0] = 4'h0;
    txn(2'b01, 0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_write_wait();
    addr_q[1] = 32'h4000_0010; wstrb_q[1] = 4'hF;
    txn(2'b10, 3, 32'h0, 1'b0);
  endtask

  task automatic test_rr_fixed();
    for (int i = 0; i < 4; i++) txn(2'b11, $urandom_range(0, 2), $urandom, 1'b1);
    for (int i = 0; i < 3; i++) txn(2'b11, $urandom_range(0, 2), $urandom, 1'b0);
  endtask

  task automatic test_timeout();
    txn(2'b10, 50, 32'h0, 1'b1);
    txn(2'b01, 50, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_valid_i = '0; s_ready_i = 1'b1;
      #1;
      vectors++;
      if (m_ready_o !== '0 || s_valid_o !== 1'b0) begin
        errors++; $display("FAIL late_ready: got rdy=%b sv=%b want 00/0", m_ready_o, s_valid_o);
      end
    end
    s_ready_i = 1'b0;
  endtask

  task automatic test_remap();
    addr_q[0] = 32'h3000_0100; txn(2'b01, 0, $urandom, 1'b0);
    addr_q[1] = 32'hA000_0004; txn(2'b10, 1, $urandom, 1'b0);
    addr_q[0] = 32'h1000_0000; txn(2'b01, 0, $urandom, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      txn(N'($urandom_range(1, 3)), ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3),
          $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_valid_i = 2'b10; rr_en_i = 1'b0;
    #1;
    @(negedge clk); #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({core_rst_n_o, s_valid_o, m_ready_o, grant_o, err_o, err_id_o} !== '0) begin
      errors++; $display("FAIL mid_reset: got rst=%b sv=%b rdy=%b g=%0d err=%b id=%0d want all zero",
                         core_rst_n_o, s_valid_o, m_ready_o, grant_o, err_o, err_id_o);
    end
    hold_release();
    txn(2'b11, 0, 32'hCAFE_0001, 1'b1);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_write_wait();
    test_rr_fixed();
    test_timeout();
    test_remap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
